// File: rtl/alu_rs_bank.sv
// Age-ordered ALU reservation station bank: CDB operand capture, oldest-ready-first issue, flush.
// Optional ALU_RS_WAKEUP_BYPASS_EN lets an entry completed by the current CDB broadcast issue that same cycle.
module alu_rs_bank #(
    parameter int WIDTH   = 31,
    parameter int ROB     = 2,
    parameter int C_WIDTH = 3,
    parameter int DEPTH   = 4
) (
    input  logic                         clk,
    input  logic                         clear,
    input  logic                         flush,
    input  logic                         writeReq,
    input  logic                         ready1,
    input  logic                         ready2,
    input  logic signed [WIDTH:0]        value1,
    input  logic signed [WIDTH:0]        value2,
    input  logic [ROB:0]                 rob1,
    input  logic [ROB:0]                 rob2,
    input  logic [ROB:0]                 robInstr,
    input  logic [C_WIDTH:0]             ALUControl,
    input  logic                         validBroadcast,
    input  logic [ROB:0]                 cdbRob,
    input  logic signed [WIDTH:0]        cdbValue,
    input  logic                         issueReady,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         issueValid,
    output logic [ROB:0]                 issueRob,
    output logic [C_WIDTH:0]             issueCtrl,
    output logic signed [WIDTH:0]        issueSrc1,
    output logic signed [WIDTH:0]        issueSrc2
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    logic [DEPTH-1:0]              busy_q, busy_d, rdy1_q, rdy1_d, rdy2_q, rdy2_d;
    logic [DEPTH-1:0][ROB:0]       tag1_q, tag1_d, tag2_q, tag2_d, dest_q, dest_d;
    logic [DEPTH-1:0][C_WIDTH:0]   ctrl_q, ctrl_d;
    logic [DEPTH-1:0][WIDTH:0]     val1_q, val1_d, val2_q, val2_d;
    logic [DEPTH-1:0][DEPTH-1:0]   older_q, older_d;

    logic [DEPTH-1:0] hit1, hit2, req, grant, alloc_oh;
    logic [IW-1:0]    gsel;
    logic [CW-1:0]    cnt;
    logic             found, alloc_en, issue_fire, cap1, cap2;

    always_comb begin
        cnt      = '0;
        hit1     = '0;
        hit2     = '0;
        req      = '0;
        grant    = '0;
        alloc_oh = '0;
        found    = 1'b0;
        gsel     = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            cnt     = cnt + {{(CW-1){1'b0}}, busy_q[i]};
            hit1[i] = busy_q[i] & ~rdy1_q[i] & validBroadcast & (cdbRob == tag1_q[i]);
            hit2[i] = busy_q[i] & ~rdy2_q[i] & validBroadcast & (cdbRob == tag2_q[i]);
`ifdef ALU_RS_WAKEUP_BYPASS_EN
            req[i]  = busy_q[i] & (rdy1_q[i] | hit1[i]) & (rdy2_q[i] | hit2[i]);
`else
            req[i]  = busy_q[i] & rdy1_q[i] & rdy2_q[i];
`endif
            if (!busy_q[i] && !found) begin
                alloc_oh[i] = 1'b1;
                found       = 1'b1;
            end
        end
        // An entry wins only if no other requester is older than it.
        for (int unsigned i = 0; i < DEPTH; i++) begin
            grant[i] = req[i] & ~|(req & older_q[i]);
            if (grant[i]) gsel = IW'(i);
        end
        count      = cnt;
        full       = (cnt == CW'(DEPTH));
        alloc_en   = writeReq & ~full;
        issueValid = |req;
        issue_fire = issueValid & issueReady;
        issueRob   = dest_q[gsel];
        issueCtrl  = ctrl_q[gsel];
        issueSrc1  = val1_q[gsel];
        issueSrc2  = val2_q[gsel];
`ifdef ALU_RS_WAKEUP_BYPASS_EN
        if (hit1[gsel]) issueSrc1 = cdbValue;
        if (hit2[gsel]) issueSrc2 = cdbValue;
`endif
        cap1 = ~ready1 & validBroadcast & (cdbRob == rob1);
        cap2 = ~ready2 & validBroadcast & (cdbRob == rob2);
    end

    always_comb begin
        busy_d  = busy_q;
        rdy1_d  = rdy1_q;
        rdy2_d  = rdy2_q;
        tag1_d  = tag1_q;
        tag2_d  = tag2_q;
        dest_d  = dest_q;
        ctrl_d  = ctrl_q;
        val1_d  = val1_q;
        val2_d  = val2_q;
        older_d = older_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (hit1[i]) begin
                rdy1_d[i] = 1'b1;
                val1_d[i] = cdbValue;
            end
            if (hit2[i]) begin
                rdy2_d[i] = 1'b1;
                val2_d[i] = cdbValue;
            end
            if (issue_fire && grant[i]) busy_d[i] = 1'b0;
            if (alloc_en && alloc_oh[i]) begin
                busy_d[i]  = 1'b1;
                rdy1_d[i]  = ready1 | cap1;
                rdy2_d[i]  = ready2 | cap2;
                val1_d[i]  = cap1 ? cdbValue : value1;
                val2_d[i]  = cap2 ? cdbValue : value2;
                tag1_d[i]  = rob1;
                tag2_d[i]  = rob2;
                dest_d[i]  = robInstr;
                ctrl_d[i]  = ALUControl;
                // New entry is younger than every currently busy entry.
                older_d[i] = busy_q;
                for (int unsigned r = 0; r < DEPTH; r++) begin
                    if (r != i) older_d[r][i] = 1'b0;
                end
            end
        end
        if (flush) busy_d = '0;
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            busy_q  <= '0;
            rdy1_q  <= '0;
            rdy2_q  <= '0;
            tag1_q  <= '0;
            tag2_q  <= '0;
            dest_q  <= '0;
            ctrl_q  <= '0;
            val1_q  <= '0;
            val2_q  <= '0;
            older_q <= '0;
        end else begin
            busy_q  <= busy_d;
            rdy1_q  <= rdy1_d;
            rdy2_q  <= rdy2_d;
            tag1_q  <= tag1_d;
            tag2_q  <= tag2_d;
            dest_q  <= dest_d;
            ctrl_q  <= ctrl_d;
            val1_q  <= val1_d;
            val2_q  <= val2_d;
            older_q <= older_d;
        end
    end
endmodule

// File: tb/tb_alu_rs_bank.sv
// Scoreboard bench for alu_rs_bank: stimulus pushes expected issues, a negedge monitor pops and compares.
module tb_alu_rs_bank;
    logic        clk = 1'b0;
    logic        clear, flush, writeReq, ready1, ready2, validBroadcast, issueReady;
    logic [31:0] value1, value2, cdbValue;
    logic [2:0]  rob1, rob2, robInstr, cdbRob;
    logic [3:0]  ALUControl;
    logic        full, issueValid;
    logic [2:0]  count, issueRob;
    logic [3:0]  issueCtrl;
    logic [31:0] issueSrc1, issueSrc2;

    int checks = 0;
    int errors = 0;

`ifdef ALU_RS_WAKEUP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [2:0]  rob;
        logic [3:0]  ctrl;
        logic [31:0] s1;
        logic [31:0] s2;
    } exp_t;
    exp_t sb[$];

    alu_rs_bank #(.WIDTH(31), .ROB(2), .C_WIDTH(3), .DEPTH(4)) dut (
        .clk(clk), .clear(clear), .flush(flush), .writeReq(writeReq),
        .ready1(ready1), .ready2(ready2), .value1(value1), .value2(value2),
        .rob1(rob1), .rob2(rob2), .robInstr(robInstr), .ALUControl(ALUControl),
        .validBroadcast(validBroadcast), .cdbRob(cdbRob), .cdbValue(cdbValue),
        .issueReady(issueReady), .full(full), .count(count), .issueValid(issueValid),
        .issueRob(issueRob), .issueCtrl(issueCtrl), .issueSrc1(issueSrc1), .issueSrc2(issueSrc2)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (clear === 1'b0 && flush === 1'b0 && issueValid === 1'b1 && issueReady === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL issue_unexpected actual=rob%0d required=no_issue", issueRob);
            end else begin
                exp_t e;
                exp_t got;
                e   = sb.pop_front();
                got = '{rob: issueRob, ctrl: issueCtrl, s1: issueSrc1, s2: issueSrc2};
                if (got !== e) begin
                    errors++;
                    $display("FAIL issue actual=rob%0d ctrl%0h %0h %0h required=rob%0d ctrl%0h %0h %0h",
                             got.rob, got.ctrl, got.s1, got.s2, e.rob, e.ctrl, e.s1, e.s2);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic set_wr(input logic [2:0] dst, input logic [3:0] ctl,
                          input logic r1, input logic [31:0] v1, input logic [2:0] t1,
                          input logic r2, input logic [31:0] v2, input logic [2:0] t2);
        writeReq   = 1'b1;
        robInstr   = dst;
        ALUControl = ctl;
        ready1     = r1;
        value1     = v1;
        rob1       = t1;
        ready2     = r2;
        value2     = v2;
        rob2       = t2;
    endtask

    task automatic expect_issue(input logic [2:0] dst, input logic [3:0] ctl,
                                input logic [31:0] s1, input logic [31:0] s2);
        sb.push_back('{rob: dst, ctrl: ctl, s1: s1, s2: s2});
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (count !== 3'd0 && n < 20) begin
            tick();
            n++;
        end
        chk(name, 64'(count), 64'd0);
    endtask

    initial begin
        clear = 1'b1; flush = 1'b0; writeReq = 1'b0; ready1 = 1'b0; ready2 = 1'b0;
        value1 = '0; value2 = '0; rob1 = '0; rob2 = '0; robInstr = '0; ALUControl = '0;
        validBroadcast = 1'b0; cdbRob = '0; cdbValue = '0; issueReady = 1'b0;
        tick();
        clear = 1'b0;
        chk("reset_full", 64'(full), 64'd0);
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_issue_valid", 64'(issueValid), 64'd0);
        chk("reset_issue_rob", 64'(issueRob), 64'd0);
        chk("reset_issue_ctrl", 64'(issueCtrl), 64'd0);
        chk("reset_issue_src1", 64'(issueSrc1), 64'd0);
        chk("reset_issue_src2", 64'(issueSrc2), 64'd0);

        // ready-at-dispatch instruction issues on the following cycle
        issueReady = 1'b1;
        set_wr(3'd3, 4'h2, 1'b1, 32'd5, 3'd0, 1'b1, 32'hFFFF_FFFE, 3'd0);
        expect_issue(3'd3, 4'h2, 32'd5, 32'hFFFF_FFFE);
        tick();
        writeReq = 1'b0;
        chk("ready_count_one", 64'(count), 64'd1);
        chk("ready_issue_valid", 64'(issueValid), 64'd1);
        tick();
        chk("ready_count_after", 64'(count), 64'd0);

        // four entries waiting on tag 7, then a wide broadcast
        for (int i = 0; i < 4; i++) begin
            set_wr(3'(i), 4'(8 + i), 1'b0, 32'hAAAA, 3'd7, 1'b0, 32'hBBBB, 3'd7);
            expect_issue(3'(i), 4'(8 + i), 32'd9, 32'd9);
            tick();
        end
        chk("age_full", 64'(full), 64'd1);
        chk("age_count_four", 64'(count), 64'd4);
        set_wr(3'd5, 4'h1, 1'b1, 32'd1, 3'd0, 1'b1, 32'd1, 3'd0);
        tick();
        writeReq = 1'b0;
        chk("write_while_full_count", 64'(count), 64'd4);
        chk("write_while_full_no_issue", 64'(issueValid), 64'd0);
        validBroadcast = 1'b1; cdbRob = 3'd7; cdbValue = 32'd9;
        tick();
        validBroadcast = 1'b0;
        drain("age_drain");

        // dispatch coinciding with the producer's broadcast
        set_wr(3'd6, 4'h3, 1'b0, 32'hDEAD, 3'd5, 1'b1, 32'd7, 3'd0);
        validBroadcast = 1'b1; cdbRob = 3'd5; cdbValue = 32'h1234;
        expect_issue(3'd6, 4'h3, 32'h1234, 32'd7);
        tick();
        writeReq = 1'b0; validBroadcast = 1'b0;
        drain("collision_drain");

        // backpressure holds the oldest selection
        issueReady = 1'b0;
        set_wr(3'd1, 4'h4, 1'b1, 32'd10, 3'd0, 1'b1, 32'd20, 3'd0);
        expect_issue(3'd1, 4'h4, 32'd10, 32'd20);
        tick();
        set_wr(3'd2, 4'h5, 1'b1, 32'd30, 3'd0, 1'b1, 32'd40, 3'd0);
        expect_issue(3'd2, 4'h5, 32'd30, 32'd40);
        tick();
        writeReq = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_issue_valid", 64'(issueValid), 64'd1);
            chk("bp_issue_rob", 64'(issueRob), 64'd1);
            tick();
        end
        issueReady = 1'b1;
        drain("bp_drain");

        // flush squashes busy entries and a concurrent write
        issueReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_wr(3'(i), 4'h6, 1'b0, 32'd0, 3'd6, 1'b1, 32'd0, 3'd0);
            tick();
        end
        writeReq = 1'b0;
        chk("flush_pre_count", 64'(count), 64'd3);
        set_wr(3'd4, 4'h7, 1'b1, 32'd1, 3'd0, 1'b1, 32'd2, 3'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0; writeReq = 1'b0;
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_issue_valid", 64'(issueValid), 64'd0);

        // wakeup-to-issue latency
        issueReady = 1'b1;
        set_wr(3'd4, 4'hA, 1'b1, 32'd11, 3'd0, 1'b0, 32'd0, 3'd3);
        expect_issue(3'd4, 4'hA, 32'd11, 32'h55);
        tick();
        writeReq = 1'b0;
        chk("lat_wait_no_issue", 64'(issueValid), 64'd0);
        validBroadcast = 1'b1; cdbRob = 3'd3; cdbValue = 32'h55;
        #1;
        chk("lat_broadcast_cycle_valid", 64'(issueValid), 64'(BYP));
        tick();
        validBroadcast = 1'b0;
        chk("lat_count_after_broadcast", 64'(count), BYP ? 64'd0 : 64'd1);
        drain("lat_drain");

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_rs_bank.md
Name: alu_rs_bank

Overview:
Multi-entry reservation station bank for the ALU functional unit. Holds up to DEPTH renamed ALU instructions, captures source operands from the common data bus (CDB) and issues one instruction per cycle, oldest first. It sits between dispatch/rename and the ALU, and it generalises the single ALU reservation-station entry into a parametrised, age-ordered bank with flush support.

Parameters:
WIDTH, 31, MSB index of operand data (data is WIDTH+1 bits, signed)
ROB, 2, MSB index of ROB tag (tag is ROB+1 bits)
C_WIDTH, 3, MSB index of ALU control field
DEPTH, 4, number of entries (2..16)

Ports:
clk  input  1  clock
clear  input  1  synchronous active-high reset
flush  input  1  squash all entries (branch mispredict)
writeReq  input  1  dispatch writes one instruction
ready1, ready2  input  1 each  source operand value already valid at dispatch
value1, value2  input  WIDTH+1 each  source values (valid when readyN)
rob1, rob2  input  ROB+1 each  producer ROB tags (used when !readyN)
robInstr  input  ROB+1  destination ROB tag
ALUControl  input  C_WIDTH+1  ALU operation
validBroadcast  input  1  CDB broadcast valid
cdbRob  input  ROB+1  CDB ROB tag
cdbValue  input  WIDTH+1  CDB result
issueReady  input  1  ALU accepts an instruction this cycle
full  output  1  no free entry
count  output  $clog2(DEPTH+1)  occupied entries
issueValid  output  1  an instruction is presented to the ALU
issueRob  output  ROB+1  destination tag of the issued instruction
issueCtrl  output  C_WIDTH+1  ALU control of the issued instruction
issueSrc1, issueSrc2  output  WIDTH+1 each  operands of the issued instruction

Behaviour:
- Per-entry state: busy, rdy1, rdy2, tag1, tag2, val1, val2, ctrl, dest. Bank state: DEPTH x DEPTH age matrix; older[i][j]=1 means entry j is older than entry i.
- Reset (clear): all busy, rdy, age bits and stored fields = 0 at the next edge. Outputs then read full=0, count=0, issueValid=0, and issueRob/issueCtrl/issueSrc1/issueSrc2=0.
- Allocation: writeReq & !full writes the lowest-index free entry at the next edge and sets busy=1. The entry's age row is set to the current busy vector, and its column is cleared in all other rows. writeReq while full is ignored, with no state change.
- Dispatch-time capture: if !readyN & validBroadcast & cdbRob==robN in the write cycle, the entry stores cdbValue with rdyN=1. Otherwise it stores valueN and rdyN=readyN.
- Wakeup: each busy entry with !rdyN & validBroadcast & cdbRob==tagN latches cdbValue and sets rdyN=1 at the next edge. Both sources can match the same broadcast.
- Request: req[i] = busy & rdy1 & rdy2, taken from registered state.
- Select: grant the entry i with req[i] such that no j with req[j] has older[i][j]. Exactly one grant. Issue outputs are combinational from the granted entry. issueValid = |req.
- Issue handshake: when issueValid & issueReady, the granted entry's busy clears at the next edge. If !issueReady, the entry is held and the selection may change as older entries wake.
- Free/allocate same cycle: full and allocation use the current busy vector. A slot freed by issue becomes allocatable the next cycle.
- count = popcount(busy). full = (count==DEPTH).
- flush: all busy=0 at the next edge. flush has priority over writeReq, wakeup and issue. issueValid stays combinational during the flush cycle, and the ALU side ignores it.
- Priority: clear > flush > (allocate, wakeup, issue). The latter three are independent per entry.
- Unused output fields when issueValid=0 are driven from entry 0 and carry no meaning.

Optional Feature:
Macro ALU_RS_WAKEUP_BYPASS_EN.
- Defined: req[i] also includes entries whose last missing source matches the current CDB broadcast. The matching issueSrcN is muxed from cdbValue in that cycle. Wakeup-to-issue latency is 0 cycles.
- Undefined: a woken entry is eligible at the earliest on the cycle after the broadcast. Wakeup-to-issue latency is 1 cycle.

Test Plan:
- Reset then idle: clear=1 for one cycle -> full=0, count=0, issueValid=0, all issue fields 0.
- Ready dispatch: write robInstr=3, ready1=ready2=1, value1=5, value2=-2, issueReady=1 -> next cycle issueValid=1, issueRob=3, issueSrc1=5, issueSrc2=-2. The cycle after that, count=0.
- Age order: fill 4 entries with tags 0,1,2,3, all waiting on tag 7. Broadcast tag 7 with value 9, issueReady=1 -> issues occur in order 0,1,2,3, each with operands 9. full=1 before the broadcast, and a fifth writeReq while full is ignored.
- Dispatch/CDB collision: writeReq with rob1=5, ready1=0 while the CDB broadcasts tag 5 with value 0x1234 -> the entry issues with issueSrc1=0x1234 and no further broadcast is needed.
- Backpressure: two ready entries, issueReady=0 for 3 cycles -> issueValid=1 and the same issueRob is held. Raise issueReady -> the older entry issues first.
- Flush: 3 busy entries plus a simultaneous writeReq and flush -> next cycle count=0, issueValid=0. With the bypass macro defined, a CDB-completing entry issues in the broadcast cycle. With it undefined, it issues one cycle later.
